// File: rtl/spi_frame_master.sv
// Two-requester round-robin SPI master: one 32-bit MSB-first mode-0 word per frame,
// closed by a cs-high flush pulse so the receiver's bit counter restarts every frame.
module spi_frame_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_HALVES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        ack1,
  output logic        done,
  output logic        done_id,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  output logic        cs
);

  localparam int unsigned DIV_W      = 8;
  localparam int unsigned GAP_W      = 4;
  localparam int unsigned BIT_W      = 6;
  localparam int unsigned FRAME_BITS = 32;

  if (CLK_DIV == 0 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_frame_master: CLK_DIV must be in 1..255");
  end
  if (GAP_HALVES > 15) begin : g_bad_gap_halves
    $error("spi_frame_master: GAP_HALVES must be in 0..15");
  end

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SHIFT,
    S_HOLD,
    S_FLUSH,
    S_GAP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [GAP_W-1:0] gap_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [31:0]      shreg;
  logic             rr;
  logic             owner;

  logic half_done_c;
  logic gap_last_c;
  logic grant_id_c;
  logic idle_next_c;

  assign half_done_c = (div == DIV_W'(CLK_DIV - 1));
  assign gap_last_c  = (gap_cnt == GAP_W'(GAP_HALVES - 1));
  // rr names the requester that wins a tie
  assign grant_id_c  = (req0 && req1) ? rr : req1;

  // Next cycle is an IDLE cycle without a pending ack: a grant may be issued into it
  always_comb begin
    idle_next_c = 1'b0;
    case (state)
      S_INIT:  idle_next_c = sclk && half_done_c;
      S_IDLE:  idle_next_c = !(ack0 || ack1);
      S_FLUSH: idle_next_c = sclk && half_done_c && (GAP_HALVES == 0);
      S_GAP:   idle_next_c = half_done_c && gap_last_c;
      default: idle_next_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INIT;
      div     <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rr      <= 1'b0;
      owner   <= 1'b0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      busy    <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      div  <= half_done_c ? '0 : div + DIV_W'(1);

      case (state)
        S_INIT: begin
          if (half_done_c) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk  <= 1'b0;
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        S_IDLE: begin
          div <= '0;
          if (ack0 || ack1) begin
            shreg   <= owner ? data1 : data0;
            mosi    <= owner ? data1[31] : data0[31];
            cs      <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
        end

        // Rotate on each falling edge so mosi only moves while sclk goes low
        S_SHIFT: begin
          if (half_done_c) begin
            if (!sclk) begin
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_W'(FRAME_BITS)) begin
                state <= S_HOLD;
              end else begin
                shreg <= {shreg[30:0], shreg[31]};
                mosi  <= shreg[30];
              end
            end
          end
        end

        S_HOLD: begin
          if (half_done_c) begin
            cs    <= 1'b1;
            mosi  <= 1'b0;
            state <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (half_done_c) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (GAP_HALVES == 0) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                done_id <= owner;
              end else begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end
            end
          end
        end

        S_GAP: begin
          if (half_done_c) begin
            if (gap_last_c) begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              done_id <= owner;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end

        default: begin
          state <= S_INIT;
          cs    <= 1'b1;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
          busy  <= 1'b1;
        end
      endcase

      // Grant into the coming IDLE cycle; data is sampled while the ack is high
      if (idle_next_c && (req0 || req1)) begin
        ack0  <= !grant_id_c;
        ack1  <= grant_id_c;
        owner <= grant_id_c;
        rr    <= !grant_id_c;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: two instances (slow divider with gap, fast divider without)
// against a mode-0 receiver model, a round-robin model and closed-form frame timing.
`timescale 1ns/1ps
module tb_spi_frame_master;

  localparam int unsigned A_DIV = 4;
  localparam int unsigned A_GAP = 2;
  localparam int unsigned B_DIV = 1;
  localparam int unsigned B_GAP = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst, a_req0, a_req1, a_ack0, a_ack1, a_done, a_done_id, a_busy, a_sclk, a_mosi, a_cs;
  logic [31:0] a_data0, a_data1;
  logic        b_rst, b_req0, b_req1, b_ack0, b_ack1, b_done, b_done_id, b_busy, b_sclk, b_mosi, b_cs;
  logic [31:0] b_data0, b_data1;

  spi_frame_master #(.CLK_DIV(A_DIV), .GAP_HALVES(A_GAP)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .req0(a_req0), .data0(a_data0), .ack0(a_ack0),
    .req1(a_req1), .data1(a_data1), .ack1(a_ack1),
    .done(a_done), .done_id(a_done_id), .busy(a_busy),
    .sclk(a_sclk), .mosi(a_mosi), .cs(a_cs)
  );

  spi_frame_master #(.CLK_DIV(B_DIV), .GAP_HALVES(B_GAP)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .req0(b_req0), .data0(b_data0), .ack0(b_ack0),
    .req1(b_req1), .data1(b_data1), .ack1(b_ack1),
    .done(b_done), .done_id(b_done_id), .busy(b_busy),
    .sclk(b_sclk), .mosi(b_mosi), .cs(b_cs)
  );

  // Receiver models: sample on sclk rise with cs low, clear on sclk rise with cs high
  int unsigned a_rx_cnt, a_trig, a_low_rises, a_flush_rises;
  logic [31:0] a_rx_sh, a_dout;
  always @(posedge a_sclk) begin
    if (a_cs) begin
      a_rx_cnt      <= 0;
      a_flush_rises <= a_flush_rises + 1;
    end else begin
      a_rx_sh     <= {a_rx_sh[30:0], a_mosi};
      a_rx_cnt    <= a_rx_cnt + 1;
      a_low_rises <= a_low_rises + 1;
      if (a_rx_cnt == 31) begin
        a_dout <= {a_rx_sh[30:0], a_mosi};
        a_trig <= a_trig + 1;
      end
    end
  end

  int unsigned b_rx_cnt, b_trig, b_low_rises, b_flush_rises;
  logic [31:0] b_rx_sh, b_dout;
  always @(posedge b_sclk) begin
    if (b_cs) begin
      b_rx_cnt      <= 0;
      b_flush_rises <= b_flush_rises + 1;
    end else begin
      b_rx_sh     <= {b_rx_sh[30:0], b_mosi};
      b_rx_cnt    <= b_rx_cnt + 1;
      b_low_rises <= b_low_rises + 1;
      if (b_rx_cnt == 31) begin
        b_dout <= {b_rx_sh[30:0], b_mosi};
        b_trig <= b_trig + 1;
      end
    end
  end

  // Protocol watch: mosi steady across sclk rise, acks only while not busy
  logic a_sclk_q, a_mosi_q, b_sclk_q, b_mosi_q;
  int unsigned a_viol, b_viol, a_done_n, a_ack1_n;
  always @(negedge clk) begin
    a_sclk_q <= a_sclk;
    a_mosi_q <= a_mosi;
    b_sclk_q <= b_sclk;
    b_mosi_q <= b_mosi;
    a_viol   <= a_viol + int'(a_sclk === 1'b1 && a_sclk_q === 1'b0 && a_mosi !== a_mosi_q)
                       + int'((a_ack0 || a_ack1) && a_busy);
    b_viol   <= b_viol + int'(b_sclk === 1'b1 && b_sclk_q === 1'b0 && b_mosi !== b_mosi_q)
                       + int'((b_ack0 || b_ack1) && b_busy);
    a_done_n <= a_done_n + int'(a_done === 1'b1);
    a_ack1_n <= a_ack1_n + int'(a_ack1 === 1'b1);
  end

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic        a_last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_wait_ack(input int budget, output int unsigned t);
    logic seen;
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      if (a_ack0 || a_ack1) begin seen = 1'b1; t = cyc; break; end
      tick();
    end
    check("a_ack_in_budget", 64'(seen), 64'd1);
  endtask

  task automatic a_wait_done(input int budget, output int unsigned t);
    logic seen;
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      if (a_done) begin seen = 1'b1; t = cyc; break; end
      tick();
    end
    check("a_done_in_budget", 64'(seen), 64'd1);
  endtask

  task automatic b_wait_ack(input int budget, output int unsigned t);
    logic seen;
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      if (b_ack0 || b_ack1) begin seen = 1'b1; t = cyc; break; end
      tick();
    end
    check("b_ack_in_budget", 64'(seen), 64'd1);
  endtask

  task automatic b_wait_done(input int budget, output int unsigned t);
    logic seen;
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < budget; i++) begin
      if (b_done) begin seen = 1'b1; t = cyc; break; end
      tick();
    end
    check("b_done_in_budget", 64'(seen), 64'd1);
  endtask

  // One full frame on instance A, checked against the arbitration and timing model
  task automatic a_frame(input logic want0, input logic want1, input logic [31:0] d0,
                         input logic [31:0] d1, input logic keep);
    int unsigned t_a, t_d, trig0, low0, fl0;
    logic        exp_id;
    logic [31:0] exp_word;
    exp_id   = (want0 && want1) ? !a_last : want1;
    exp_word = exp_id ? d1 : d0;
    a_data0 = d0;
    a_data1 = d1;
    a_req0  = want0;
    a_req1  = want1;
    a_wait_ack(600, t_a);
    check("a_grant", 64'({a_ack1, a_ack0}), exp_id ? 64'd2 : 64'd1);
    trig0  = a_trig;
    low0   = a_low_rises;
    fl0    = a_flush_rises;
    a_last = exp_id;
    if (!keep) begin
      a_req0 = 1'b0;
      a_req1 = 1'b0;
    end
    tick();
    check("a_ack_one_cycle", 64'({a_ack1, a_ack0}), 64'd0);
    a_wait_done(600, t_d);
    check("a_done_latency", 64'(t_d - t_a), 64'(1 + (67 + A_GAP) * A_DIV));
    check("a_done_id", 64'(a_done_id), 64'(exp_id));
    check("a_rx_word", 64'(a_dout), 64'(exp_word));
    check("a_rx_trigger_once", 64'(a_trig - trig0), 64'd1);
    check("a_rises_cs_low", 64'(a_low_rises - low0), 64'd32);
    check("a_rises_cs_high", 64'(a_flush_rises - fl0), 64'd1);
  endtask

  int unsigned t1, t2, t3, t4, base0, base1, base2;
  logic        seen_bit;
  int unsigned pat;
  logic [31:0] r0, r1;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_req0 = 1'b0; a_req1 = 1'b0; a_data0 = '0; a_data1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_data0 = '0; b_data1 = '0;
    a_last = 1'b1;
    repeat (3) tick();

    check("rst_cs", 64'(a_cs), 64'd1);
    check("rst_sclk", 64'(a_sclk), 64'd0);
    check("rst_mosi", 64'(a_mosi), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd1);
    check("rst_acks_done", 64'({a_ack0, a_ack1, a_done, a_done_id}), 64'd0);

    // Reset release with CLK_DIV=1: low half, high half, IDLE on the third cycle
    a_rst = 1'b0;
    b_rst = 1'b0;
    base0 = b_flush_rises;
    check("b_c1_busy", 64'(b_busy), 64'd1);
    check("b_c1_sclk", 64'(b_sclk), 64'd0);
    tick();
    check("b_c2_sclk", 64'(b_sclk), 64'd1);
    check("b_c2_cs", 64'(b_cs), 64'd1);
    check("b_c2_busy", 64'(b_busy), 64'd1);
    tick();
    check("b_c3_busy", 64'(b_busy), 64'd0);
    check("b_c3_sclk", 64'(b_sclk), 64'd0);
    check("b_init_flush_rises", 64'(b_flush_rises - base0), 64'd1);

    // Back-to-back frames without gap: all-ones then 1
    base1 = b_trig;
    b_data0 = 32'hFFFF_FFFF;
    b_req0  = 1'b1;
    b_wait_ack(20, t1);
    check("b_first_ack0", 64'(b_ack0), 64'd1);
    tick();
    b_data0 = 32'h0000_0001;
    b_wait_done(200, t2);
    check("b_first_latency", 64'(t2 - t1), 64'(1 + (67 + B_GAP) * B_DIV));
    check("b_first_word", 64'(b_dout), 64'hFFFF_FFFF);
    check("b_regrant_in_done_cycle", 64'(b_ack0), 64'd1);
    t3 = cyc;
    b_req0 = 1'b0;
    tick();
    b_wait_done(200, t4);
    check("b_second_latency", 64'(t4 - t3), 64'(1 + (67 + B_GAP) * B_DIV));
    check("b_second_word", 64'(b_dout), 64'h0000_0001);
    check("b_second_done_id", 64'(b_done_id), 64'd0);
    check("b_two_triggers", 64'(b_trig - base1), 64'd2);

    // Single requester 0 frame
    a_frame(1'b1, 1'b0, 32'hA5C3_0F01, 32'h0, 1'b0);

    // Both requesters held: grants alternate by round-robin
    for (int k = 0; k < 4; k++) begin
      a_frame(1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, (k != 3));
    end

    // Requester 1 appears and vanishes during a busy frame
    a_data0 = $urandom;
    a_req0  = 1'b1;
    a_wait_ack(600, t1);
    check("a_drop_test_grant", 64'({a_ack1, a_ack0}), 64'd1);
    a_req0 = 1'b0;
    a_last = 1'b0;
    base1 = a_ack1_n;
    base2 = a_done_n;
    repeat (10) tick();
    a_req1 = 1'b1;
    repeat (40) tick();
    a_req1 = 1'b0;
    a_wait_done(600, t2);
    repeat (30) tick();
    check("a_no_ack1_for_dropped", 64'(a_ack1_n - base1), 64'd0);
    check("a_single_done", 64'(a_done_n - base2), 64'd1);
    check("a_idle_after_drop", 64'(a_busy), 64'd0);

    // Reset in the middle of bit 15
    a_data0 = $urandom;
    a_req0  = 1'b1;
    a_wait_ack(600, t1);
    a_req0 = 1'b0;
    seen_bit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (a_rx_cnt == 17) begin seen_bit = 1'b1; break; end
      tick();
    end
    check("a_reached_bit15", 64'(seen_bit), 64'd1);
    base2 = a_done_n;
    a_rst = 1'b1;
    tick();
    check("a_midrst_cs", 64'(a_cs), 64'd1);
    check("a_midrst_sclk", 64'(a_sclk), 64'd0);
    check("a_midrst_busy", 64'(a_busy), 64'd1);
    tick();
    a_rst  = 1'b0;
    a_last = 1'b1;
    base0 = a_flush_rises;
    repeat (2 * A_DIV + 2) tick();
    check("a_midrst_flush", 64'(a_flush_rises - base0), 64'd1);
    check("a_midrst_rx_cleared", 64'(a_rx_cnt), 64'd0);
    check("a_midrst_no_done", 64'(a_done_n - base2), 64'd0);
    check("a_midrst_idle", 64'(a_busy), 64'd0);
    a_frame(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);

    // Random request patterns and words
    for (int k = 0; k < 6; k++) begin
      pat = $urandom_range(3, 1);
      r0  = $urandom;
      r1  = $urandom;
      a_frame(pat[0], pat[1], r0, r1, 1'b0);
    end

    repeat (4) tick();
    check("a_protocol_violations", 64'(a_viol), 64'd0);
    check("b_protocol_violations", 64'(b_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
